alu_op_sequencer: RTL
=====================

// Module: alu_op_sequencer
// PURPOSE
//  Front-end control stage that sits directly upstream of the 8-bit arithmetic unit.
//  Accepts one operation request (op, A, B) over a valid/ready handshake and drives the
//  unit's operand inputs and one-hot enables for a fixed settle window.
//  Captures the unit's 16-bit result and returns it over a second valid/ready handshake.
//  Divide-by-zero is trapped here and never reaches the divider.
// PARAMETERS
//  SETTLE_CYCLES    2        cycles enables are held before result is sampled; legal range >=1
//  DIV_ZERO_RESULT  16'hFFFF value returned on rsp_result when a divide has B==0
// PORTS
//  clk         in   1   single clock, all state updates on rising edge
//  rst_n       in   1   synchronous, active-low reset
//  req_valid   in   1   request present
//  req_ready   out  1   sequencer can accept a request
//  req_op      in   2   00 add, 01 sub, 10 mul, 11 div
//  req_a       in   8   operand A, signed
//  req_b       in   8   operand B, signed
//  au_a        out  8   operand A to arithmetic unit
//  au_b        out  8   operand B to arithmetic unit
//  au_op       out  2   op code to arithmetic unit (mirror of latched op)
//  add_en      out  1   one-hot enable: add
//  sub_en      out  1   one-hot enable: sub
//  mul_en      out  1   one-hot enable: mul
//  div_en      out  1   one-hot enable: div
//  au_result   in   16  result from arithmetic unit
//  rsp_valid   out  1   response present
//  rsp_ready   in   1   consumer accepts response
//  rsp_result  out  16  captured result
//  rsp_op      out  2   op code of this response
//  rsp_div0    out  1   1 = divide-by-zero trap, rsp_result = DIV_ZERO_RESULT
//  busy        out  1   state != IDLE
// BEHAVIOUR
//  Reset: rst_n==0 at a rising edge forces IDLE.
//   - All outputs except req_ready go to 0, including au_a/au_b, rsp_result and the enables.
//   - req_ready = 1 in the first cycle after reset.
//   - Reset mid-operation discards the pending op; no response is emitted.
//  FSM states: IDLE, EXEC, DONE.
//  IDLE:
//   - req_ready = 1.
//   - Accept on req_valid & req_ready: latch req_op/a/b into au_op/au_a/au_b.
//   - If op==11 and req_b==0: go to DONE; rsp_result = DIV_ZERO_RESULT; rsp_div0 = 1; rsp_op = 11.
//   - Else: go to EXEC; counter = SETTLE_CYCLES-1.
//  EXEC:
//   - Exactly one enable high, selected by au_op; all others 0.
//   - Counter decrements each cycle.
//   - At the edge where counter==0: rsp_result <= au_result; rsp_div0 <= 0; rsp_op <= au_op; go to DONE.
//  DONE:
//   - rsp_valid = 1; enables 0.
//   - rsp_result/rsp_op/rsp_div0 held stable until the handshake completes.
//   - On rsp_ready: go to IDLE. rsp_valid drops the next cycle. rsp_* data regs keep their last value.
//  Request/response rules:
//   - req_ready = 0 in EXEC and DONE; one operation in flight, no overlap.
//   - req_valid while !req_ready is ignored; the requester holds it.
//   - au_a/au_b/au_op hold from acceptance until the next acceptance.
//  Latency, counting edges from the accepting edge:
//   - Normal op: rsp_valid visible after SETTLE_CYCLES edges.
//   - Div0 op: rsp_valid visible after 1 edge.
//   - Minimum spacing between acceptances = SETTLE_CYCLES+2 cycles with rsp_ready held 1.
//  Widths: au_result is passed through unmodified; no sign handling here.
//   - Divide result format {quotient, remainder} is owned by the arithmetic unit.
//  Enables are never asserted in IDLE or DONE, and never more than one at a time.
// TESTING
//  1. Reset held 3 cycles, then released -> req_ready=1, rsp_valid=0, all enables 0, au_a=0.
//  2. add A=8'd5, B=8'd3, stub au_result=16'h0008, rsp_ready=1, SETTLE=2
//     -> add_en high exactly 2 cycles; rsp_valid after edge 2; rsp_result=16'h0008; rsp_op=00.
//  3. div A=8'd20, B=8'd0 -> div_en never asserted; rsp_valid after 1 edge;
//     rsp_result=16'hFFFF; rsp_div0=1.
//  4. mul A=-3, B=4 with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_result=16'hFFF4 stable
//     throughout; req_ready=0 throughout; IDLE one edge after rsp_ready=1.
//  5. Back-to-back sub then div (A=-7, B=2) with req_valid held 1 -> second op accepted only
//     in IDLE; one-hot enables throughout; responses in order.
//  6. rst_n=0 during EXEC of a mul -> next cycle IDLE, mul_en=0, no rsp_valid pulse.

Source files
------------

// File: rtl/alu_seq_if.sv
// Handshake and arithmetic-unit bus between a requester, the op sequencer and the 8-bit arithmetic unit.
// The slave modport is the sequencer; the master modport is the environment (requester, unit, consumer).
interface alu_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic [7:0]  au_a;
  logic [7:0]  au_b;
  logic [1:0]  au_op;
  logic        add_en;
  logic        sub_en;
  logic        mul_en;
  logic        div_en;
  logic [15:0] au_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [1:0]  rsp_op;
  logic        rsp_div0;
  logic        busy;

  modport slave (
    input  req_valid, req_op, req_a, req_b, au_result, rsp_ready,
    output req_ready, au_a, au_b, au_op, add_en, sub_en, mul_en, div_en,
           rsp_valid, rsp_result, rsp_op, rsp_div0, busy
  );

  modport master (
    output req_valid, req_op, req_a, req_b, au_result, rsp_ready,
    input  req_ready, au_a, au_b, au_op, add_en, sub_en, mul_en, div_en,
           rsp_valid, rsp_result, rsp_op, rsp_div0, busy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issues one op at a time to the arithmetic unit: holds operands and a one-hot enable for a
// settle window, captures the result and returns it; divide-by-zero is answered locally.
module alu_op_sequencer #(
  parameter int          SETTLE_CYCLES   = 2,
  parameter logic [15:0] DIV_ZERO_RESULT = 16'hFFFF
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      bus.req_ready  <= 1'b1;
      bus.au_a       <= '0;
      bus.au_b       <= '0;
      bus.au_op      <= '0;
      bus.add_en     <= 1'b0;
      bus.sub_en     <= 1'b0;
      bus.mul_en     <= 1'b0;
      bus.div_en     <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_op     <= '0;
      bus.rsp_div0   <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.au_a      <= bus.req_a;
            bus.au_b      <= bus.req_b;
            bus.au_op     <= bus.req_op;
            bus.req_ready <= 1'b0;
            bus.busy      <= 1'b1;
            // Zero divisor never reaches the divider; answer straight away.
            if (bus.req_op == 2'b11 && bus.req_b == 8'd0) begin
              state          <= DONE;
              bus.rsp_valid  <= 1'b1;
              bus.rsp_result <= DIV_ZERO_RESULT;
              bus.rsp_op     <= 2'b11;
              bus.rsp_div0   <= 1'b1;
            end else begin
              state <= EXEC;
              cnt   <= CW'(SETTLE_CYCLES - 1);
              {bus.div_en, bus.mul_en, bus.sub_en, bus.add_en} <= 4'b0001 << bus.req_op;
            end
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            state          <= DONE;
            bus.rsp_valid  <= 1'b1;
            bus.rsp_result <= bus.au_result;
            bus.rsp_op     <= bus.au_op;
            bus.rsp_div0   <= 1'b0;
            {bus.div_en, bus.mul_en, bus.sub_en, bus.add_en} <= 4'b0000;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            bus.busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
